// File: rtl/add32_stream_acc.sv
// Streaming accumulator: folds a packet of 32-bit operands into a running sum
// through an add/sub core, then presents the total until the consumer takes it.

module add32 (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        sub,
    input  logic        sign,
    output logic [31:0] sum,
    output logic        ovf,
    output logic [31:0] sat_val
);
    logic [32:0] full;
    logic        carry;
    logic        signed_ovf;
    logic        unsigned_ovf;

    // Subtraction as a + ~b + 1, so the carry out is the inverted borrow.
    assign full  = {1'b0, a} + {1'b0, (sub ? ~b : b)} + {32'd0, sub};
    assign carry = full[32];
    assign sum   = full[31:0];

    assign signed_ovf   = sub ? ((a[31] != b[31]) && (sum[31] != a[31]))
                              : ((a[31] == b[31]) && (sum[31] != a[31]));
    assign unsigned_ovf = sub ? ~carry : carry;
    assign ovf          = sign ? signed_ovf : unsigned_ovf;

    // A signed overflow can only run away from zero in the direction of a's sign.
    assign sat_val = sign ? (a[31] ? 32'h8000_0000 : 32'h7FFF_FFFF)
                          : (sub ? 32'h0000_0000 : 32'hFFFF_FFFF);
endmodule

module add32_stream_acc #(
    parameter bit SAT_EN = 1'b0,
    parameter int CNT_W  = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_data,
    input  logic             in_sub,
    input  logic             in_sign,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_data,
    output logic             out_ovf,
    output logic [CNT_W-1:0] out_count
);
    typedef enum logic {ACC, HOLD} state_t;

    state_t             state;
    state_t             state_next;
    logic               ready_en;
    logic               accept;
    logic               drain;
    logic [31:0]        acc;
    logic               ovf_sticky;
    logic [CNT_W-1:0]   count;
    logic [31:0]        beat_sum;
    logic               beat_ovf;
    logic [31:0]        beat_sat;

    add32 u_add32 (
        .a       (acc),
        .b       (in_data),
        .sub     (in_sub),
        .sign    (in_sign),
        .sum     (beat_sum),
        .ovf     (beat_ovf),
        .sat_val (beat_sat)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ACC;
        end else begin
            state <= state_next;
        end
    end

    // Keeps in_ready low until the first edge after reset is released.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ready_en <= 1'b0;
        end else begin
            ready_en <= 1'b1;
        end
    end

    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        accept     = 1'b0;
        drain      = 1'b0;
        case (state)
            ACC: begin
                in_ready = ready_en & ~clr;
                accept   = in_valid & in_ready;
                if (accept && in_last) begin
                    state_next = HOLD;
                end
            end
            HOLD: begin
                out_valid = 1'b1;
                drain     = out_ready;
                if (out_ready) begin
                    state_next = ACC;
                end
            end
            default: state_next = ACC;
        endcase
        if (clr) begin
            state_next = ACC;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc        <= 32'd0;
            ovf_sticky <= 1'b0;
            count      <= '0;
        end else if (clr || drain) begin
            acc        <= 32'd0;
            ovf_sticky <= 1'b0;
            count      <= '0;
        end else if (accept) begin
            acc        <= (SAT_EN && beat_ovf) ? beat_sat : beat_sum;
            ovf_sticky <= ovf_sticky | beat_ovf;
            if (count != {CNT_W{1'b1}}) begin
                count <= count + {{(CNT_W-1){1'b0}}, 1'b1};
            end
        end
    end

    // Nothing is accepted while HOLD, so the live accumulator is the result.
    assign out_data  = acc;
    assign out_ovf   = ovf_sticky;
    assign out_count = count;
endmodule

// File: doc/add32_stream_acc.md
Name: add32_stream_acc

Overview:
Sequential accumulator stage that consumes the combinational Add32 adder. It accepts a stream of 32-bit operands over a valid/ready handshake and adds or subtracts each one into a running sum, in signed or unsigned mode. It tracks a sticky overflow flag and returns the packet total over a second valid/ready handshake. It sits between operand-producing logic and the result consumer, and instantiates Add32 (or equivalent logic) for the per-beat add/sub and overflow.

Parameters:
SAT_EN, 0, 1 = clamp the accumulator on overflow; 0 = wrap modulo 2^32.
CNT_W, 8, width of the beat counter.

Ports:
clk  input  1  clock, rising edge.
rst_n  input  1  asynchronous active-low reset.
clr  input  1  synchronous clear; highest priority after reset.
in_valid  input  1  operand beat valid.
in_ready  output  1  operand beat accepted when in_valid & in_ready.
in_data  input  32  operand (B side of adder; A side = accumulator).
in_sub  input  1  1 = acc - in_data, 0 = acc + in_data.
in_sign  input  1  1 = signed (two's complement) overflow rule, 0 = unsigned rule.
in_last  input  1  marks the final beat of a packet.
out_valid  output  1  packet result valid.
out_ready  input  1  result consumed when out_valid & out_ready.
out_data  output  32  accumulated result.
out_ovf  output  1  sticky: overflow occurred on any beat of the packet.
out_count  output  CNT_W  beats accepted in the packet; saturates at 2^CNT_W-1.

Behaviour:
- Reset: rst_n low asynchronously forces state=ACC, acc=0, out_valid=0, out_data=0, out_ovf=0, out_count=0, in_ready=0. in_ready becomes 1 on the first clock edge after rst_n deasserts.
- Two-state FSM: ACC and HOLD.
- ACC:
  - in_ready=1 and out_valid=0.
  - On each accepted beat: acc <= f(acc, in_data, in_sub, in_sign); ovf_sticky |= beat overflow; count++ (saturating).
- Beat overflow rules (each beat is judged using that beat's own in_sub/in_sign; modes may mix within a packet):
  - Signed add: operands have the same sign and the result sign differs.
  - Signed sub: operand signs differ and the result sign differs from acc.
  - Unsigned add: carry out of bit 31.
  - Unsigned sub: borrow, i.e. acc < in_data.
- Saturation:
  - SAT_EN=0: acc takes the wrapped 32-bit result.
  - SAT_EN=1 and overflow: signed positive overflow -> 0x7FFFFFFF; signed negative overflow -> 0x80000000; unsigned add -> 0xFFFFFFFF; unsigned sub -> 0x00000000.
- in_last accepted:
  - The beat is processed as above, and the FSM moves to HOLD on the same edge.
  - out_valid=1 in the next cycle, i.e. latency of one clock from the last-beat accept edge.
  - out_data = the updated acc, out_ovf/out_count include that beat.
- HOLD:
  - in_ready=0.
  - out_data, out_ovf and out_count are held stable while out_ready=0.
  - On out_valid & out_ready: acc, ovf_sticky and count clear to 0, out_valid drops, and the FSM returns to ACC. in_ready=1 in the following cycle, with no overlap of packets.
- clr=1 (any state):
  - In that cycle, in_ready is forced 0, so no beat is accepted.
  - On the edge: acc, sticky, count and out_valid are cleared, and the FSM moves to ACC.
  - clr in HOLD discards the pending result.
- Count saturation: out_count stops at 2^CNT_W-1 while the sum keeps accumulating.
- Zero-length packets are impossible; every packet has at least one beat, the last one.
- Reset mid-packet or mid-HOLD: all state is lost immediately and out_valid drops without waiting for a clock.

Test Plan:
1. Unsigned add: beats 100, 200, 300(last), sign=0, sub=0 -> out_data=600, out_ovf=0, out_count=3; out_valid rises one cycle after the last accept.
2. Signed overflow: 0x7FFFFFFF then +1(last), sign=1 -> SAT_EN=0: out_data=0x80000000, out_ovf=1. SAT_EN=1: out_data=0x7FFFFFFF, out_ovf=1.
3. Unsigned borrow: 5 (add), then 7 (sub, last), sign=0 -> SAT_EN=0: out_data=0xFFFFFFFE, out_ovf=1. SAT_EN=1: out_data=0, out_ovf=1.
4. Backpressure plus signed: -100, -100(last), sign=1, out_ready=0 for 5 cycles -> out_data=0xFFFFFF38 (-200) held stable, out_ovf=0, in_ready=0 throughout. After the handshake, in_ready=1 next cycle and the next packet 1(last) -> out_data=1, count=1.
5. clr after 2 beats (10, 20), then packet 7(last) -> out_data=7, out_count=1, out_ovf=0. rst_n low during HOLD -> out_valid=0 immediately, without a clock edge.
6. Streaming with CNT_W=8: 300 beats of 1, unsigned, in_valid held high -> one beat accepted per cycle, out_data=300, out_count=255 (saturated), out_ovf=0.
